// File: rtl/quad_encoder_decoder_if.sv
// Signal bundle between the encoder pins/controller and quad_encoder_decoder.
// Carries the raw A/B channels, decode configuration and the decoded outputs.
interface quad_encoder_decoder_if #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
);
  // There is no valid/ready handshake on this bundle: every input is sampled
  // on every rising clock edge, and every output is a registered level or a
  // one-cycle pulse that the consumer must sample on the following edge.
  logic             SIG_A;
  logic             SIG_B;
  logic [1:0]       MODE;
  logic             DIR_INV;
  logic [DIV_W-1:0] DIV;
  logic             CLR;
  logic             ERR_CLR;
  logic [CNT_W-1:0] POSITION;
  logic             DIR;
  logic             STEP;
  logic             LINE_PULSE;
  logic             ERR;
  logic [2:0]       DBG_STATE;

  modport master (
    output SIG_A, SIG_B, MODE, DIR_INV, DIV, CLR, ERR_CLR,
    input  POSITION, DIR, STEP, LINE_PULSE, ERR, DBG_STATE
  );

  modport slave (
    input  SIG_A, SIG_B, MODE, DIR_INV, DIV, CLR, ERR_CLR,
    output POSITION, DIR, STEP, LINE_PULSE, ERR, DBG_STATE
  );
endinterface

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: sync, optional deglitch, x1/x2/x4 decode, position and line trigger.
// Optional glitch filter is enabled by defining ENC_FILTER_EN.
module quad_encoder_decoder #(
  parameter int CNT_W    = 32,
  parameter int DIV_W    = 16,
  parameter int FILT_LEN = 4
) (
  input logic                   CLK,
  input logic                   RST_N,
  quad_encoder_decoder_if.slave enc
);

  // Two-flop synchronisers for {A,B}; fill_q marks when sync2_q holds a real sample.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] fill_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= {enc.SIG_A, enc.SIG_B};
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  logic [1:0] samp;
  logic       samp_vld;

`ifdef ENC_FILTER_EN
  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

  logic [1:0]       filt_q;
  logic             filt_vld_q;
  logic [RUN_W-1:0] run_q [2];

  // The first real sample seeds the filter so priming never sees a fake edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q     <= 2'b00;
      filt_vld_q <= 1'b0;
      run_q[0]   <= '0;
      run_q[1]   <= '0;
    end else if (fill_q[1]) begin
      if (!filt_vld_q) begin
        filt_q     <= sync2_q;
        filt_vld_q <= 1'b1;
        run_q[0]   <= '0;
        run_q[1]   <= '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (sync2_q[i] == filt_q[i]) begin
            run_q[i] <= '0;
          end else if (run_q[i] == RUN_LAST) begin
            filt_q[i] <= sync2_q[i];
            run_q[i]  <= '0;
          end else begin
            run_q[i] <= run_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign samp     = filt_q;
  assign samp_vld = filt_vld_q;
`else
  assign samp     = sync2_q;
  assign samp_vld = fill_q[1];
`endif

  // Decoder state and registered outputs.
  logic [1:0]       s_q;
  logic             primed_q;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] lph_q, lph_d;
  logic             dir_q, dir_d;
  logic             step_q;
  logic             lp_q, lp_d;
  logic             err_q, err_d;

  logic             chg;
  logic             a_chg;
  logic             one_bit;
  logic             illegal;
  logic [1:0]       fwd_next;
  logic             sign_fwd;
  logic             counted;
  logic [DIV_W-1:0] div_m1;

  always_comb begin
    chg     = primed_q && samp_vld && (samp != s_q);
    a_chg   = samp[1] ^ s_q[1];
    one_bit = a_chg ^ (samp[0] ^ s_q[0]);
    illegal = chg && !one_bit;

    // Forward Gray order 00 -> 10 -> 11 -> 01 -> 00.
    case (s_q)
      2'b00:   fwd_next = 2'b10;
      2'b10:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b01;
      default: fwd_next = 2'b00;
    endcase
    sign_fwd = (samp == fwd_next) ^ enc.DIR_INV;

    case (enc.MODE)
      2'd0:    counted = chg && one_bit &&
                         (({s_q, samp} == 4'b0010) || ({s_q, samp} == 4'b1000));
      2'd1:    counted = chg && one_bit && a_chg;
      default: counted = chg && one_bit;
    endcase

    div_m1 = enc.DIV - 1'b1;
    pos_d  = pos_q;
    lph_d  = lph_q;
    lp_d   = 1'b0;

    if (counted) begin
      pos_d = sign_fwd ? pos_q + 1'b1 : pos_q - 1'b1;
      if (sign_fwd) begin
        // >= rather than == so a DIV lowered below the phase fires next step.
        if (lph_q >= div_m1) begin
          lph_d = '0;
          lp_d  = 1'b1;
        end else begin
          lph_d = lph_q + 1'b1;
        end
      end else begin
        lph_d = (lph_q == '0) ? div_m1 : lph_q - 1'b1;
      end
    end

    if (enc.DIV == '0) begin
      lph_d = '0;
      lp_d  = 1'b0;
    end

    if (enc.CLR) begin
      pos_d = '0;
      lph_d = '0;
      lp_d  = 1'b0;
    end

    dir_d = (chg && one_bit) ? sign_fwd : dir_q;
    err_d = illegal ? 1'b1 : (enc.ERR_CLR ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_q      <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= '0;
      lph_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      lp_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (samp_vld) begin
        s_q      <= samp;
        primed_q <= 1'b1;
      end
      pos_q  <= pos_d;
      lph_q  <= lph_d;
      dir_q  <= dir_d;
      step_q <= counted;
      lp_q   <= lp_d;
      err_q  <= err_d;
    end
  end

  assign enc.POSITION   = pos_q;
  assign enc.DIR        = dir_q;
  assign enc.STEP       = step_q;
  assign enc.LINE_PULSE = lp_q;
  assign enc.ERR        = err_q;
  assign enc.DBG_STATE  = {primed_q, s_q};

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Self-checking bench for quad_encoder_decoder: directed plan items plus random steps
// checked against a Gray-index reference model.
module tb_quad_encoder_decoder;

  localparam int CNT_W    = 8;
  localparam int DIV_W    = 8;
  localparam int FILT_LEN = 4;
`ifdef ENC_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = 12;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_encoder_decoder_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) enc_if ();

  quad_encoder_decoder #(
    .CNT_W   (CNT_W),
    .DIV_W   (DIV_W),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .enc  (enc_if)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] m_s;
  int         m_pos;
  int         m_lph;
  logic       m_dir;
  logic       m_err;
  int         m_mode;
  logic       m_inv;
  int         m_div;

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic set_cfg(input int mode, input logic inv, input int div);
    m_mode = mode;
    m_inv  = inv;
    m_div  = div;
    enc_if.MODE    = mode[1:0];
    enc_if.DIR_INV = inv;
    enc_if.DIV     = div[DIV_W-1:0];
  endtask

  // Drive new {A,B}; optional CLR/ERR_CLR land on the cycle the decode registers.
  task automatic apply(input logic [1:0] ab, input logic clr_on, input logic eclr_on);
    int   d;
    logic valid, ill, cnt, fwd_s, lp;
    d     = (gidx(ab) - gidx(m_s) + 4) % 4;
    valid = (d == 1) || (d == 3);
    ill   = (d == 2);
    fwd_s = (d == 1) ^ m_inv;
    case (m_mode)
      0:       cnt = valid && (gidx(ab) + gidx(m_s) == 1);
      1:       cnt = valid && (ab[1] != m_s[1]);
      default: cnt = valid;
    endcase
    lp = 1'b0;
    if (cnt) begin
      m_pos = fwd_s ? m_pos + 1 : m_pos - 1;
      if (m_div != 0) begin
        if (fwd_s) begin
          if (m_lph >= m_div - 1) begin
            m_lph = 0;
            lp    = 1'b1;
          end else begin
            m_lph = m_lph + 1;
          end
        end else begin
          m_lph = (m_lph == 0) ? m_div - 1 : m_lph - 1;
        end
      end
    end
    if (m_div == 0) m_lph = 0;
    if (clr_on) begin
      m_pos = 0;
      m_lph = 0;
      lp    = 1'b0;
    end
    m_pos = ((m_pos % (1 << CNT_W)) + (1 << CNT_W)) % (1 << CNT_W);
    if (valid) m_dir = fwd_s;
    if (ill) m_err = 1'b1;
    else if (eclr_on) m_err = 1'b0;
    m_s = ab;
    exp_q.push_back(m_pos[CNT_W-1:0]);

    @(posedge clk);
    #1;
    enc_if.SIG_A = ab[1];
    enc_if.SIG_B = ab[0];
    for (int c = 1; c <= GAP; c++) begin
      @(posedge clk);
      #1;
      if (c == LAT - 1) begin
        enc_if.CLR     = clr_on;
        enc_if.ERR_CLR = eclr_on;
      end
      if (c == LAT) begin
        enc_if.CLR     = 1'b0;
        enc_if.ERR_CLR = 1'b0;
      end
      chk("step", {31'b0, enc_if.STEP}, {31'b0, (c == LAT) && cnt});
      chk("line_pulse", {31'b0, enc_if.LINE_PULSE}, {31'b0, (c == LAT) && lp});
    end
    chk("position", {24'b0, enc_if.POSITION}, {24'b0, exp_q.pop_front()});
    chk("dir", {31'b0, enc_if.DIR}, {31'b0, m_dir});
    chk("err", {31'b0, enc_if.ERR}, {31'b0, m_err});
  endtask

  task automatic step_fwd(input int n);
    for (int i = 0; i < n; i++) apply(gval(gidx(m_s) + 1), 1'b0, 1'b0);
  endtask

  task automatic step_rev(input int n);
    for (int i = 0; i < n; i++) apply(gval(gidx(m_s) + 3), 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    #3;
    rst_n        = 1'b0;
    enc_if.SIG_A = ab[1];
    enc_if.SIG_B = ab[0];
    #1;
    chk("rst_position", {24'b0, enc_if.POSITION}, 32'd0);
    chk("rst_dir", {31'b0, enc_if.DIR}, 32'd0);
    chk("rst_step", {31'b0, enc_if.STEP}, 32'd0);
    chk("rst_line", {31'b0, enc_if.LINE_PULSE}, 32'd0);
    chk("rst_err", {31'b0, enc_if.ERR}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_s   = ab;
    m_pos = 0;
    m_lph = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    // Priming with a non-zero input must neither count nor flag.
    for (int c = 0; c < LAT + 6; c++) begin
      @(posedge clk);
      #1;
      chk("prime_step", {31'b0, enc_if.STEP}, 32'd0);
      chk("prime_err", {31'b0, enc_if.ERR}, 32'd0);
    end
    chk("prime_position", {24'b0, enc_if.POSITION}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst_n          = 1'b1;
    enc_if.SIG_A   = 1'b0;
    enc_if.SIG_B   = 1'b0;
    enc_if.CLR     = 1'b0;
    enc_if.ERR_CLR = 1'b0;
    set_cfg(2, 1'b0, 0);
    do_reset(2'b00);

    // x4, DIV=0: 8 forward steps
    step_fwd(8);
    chk("x4_pos8", {24'b0, enc_if.POSITION}, 32'd8);
    chk("x4_dir", {31'b0, enc_if.DIR}, 32'd1);

    // x1 then x2 over the same forward sequence, then reverse through zero
    apply(m_s, 1'b1, 1'b0);
    set_cfg(0, 1'b0, 0);
    step_fwd(8);
    chk("x1_pos2", {24'b0, enc_if.POSITION}, 32'd2);
    apply(m_s, 1'b1, 1'b0);
    set_cfg(1, 1'b0, 0);
    step_fwd(8);
    chk("x2_pos4", {24'b0, enc_if.POSITION}, 32'd4);
    apply(m_s, 1'b1, 1'b0);
    set_cfg(0, 1'b0, 0);
    step_fwd(8);
    step_rev(8);
    chk("x1_back0", {24'b0, enc_if.POSITION}, 32'd0);
    step_rev(4);
    chk("x1_wrap", {24'b0, enc_if.POSITION}, 32'd255);

    // x4, DIV=4 line triggering with back-and-forth
    set_cfg(2, 1'b0, 4);
    apply(m_s, 1'b1, 1'b0);
    step_fwd(10);
    step_rev(2);
    step_fwd(2);

    // DIV=1 and inverted direction
    set_cfg(2, 1'b1, 1);
    step_fwd(3);
    step_rev(3);

    // Illegal jumps and ERR_CLR priority
    set_cfg(2, 1'b0, 3);
    apply(gval(gidx(m_s) + 2), 1'b0, 1'b0);
    chk("err_set", {31'b0, enc_if.ERR}, 32'd1);
    apply(gval(gidx(m_s) + 2), 1'b0, 1'b1);
    chk("err_wins", {31'b0, enc_if.ERR}, 32'd1);
    apply(m_s, 1'b0, 1'b1);
    chk("err_clr", {31'b0, enc_if.ERR}, 32'd0);

`ifdef ENC_FILTER_EN
    // 3-cycle glitch on A must be rejected
    @(posedge clk);
    #1;
    enc_if.SIG_A = ~m_s[1];
    repeat (3) @(posedge clk);
    #1;
    enc_if.SIG_A = m_s[1];
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      chk("glitch_step", {31'b0, enc_if.STEP}, 32'd0);
    end
    step_fwd(1);
`endif

    // Random legal/illegal steps with random configuration
    for (int i = 0; i < 150; i++) begin
      if (i % 20 == 0)
        set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
      r = $urandom_range(0, 19);
      if (r == 0)      apply(gval(gidx(m_s) + 2), 1'b0, 1'b0);
      else if (r == 1) apply(gval(gidx(m_s) + 1), 1'b1, 1'b0);
      else if (r == 2) apply(m_s, 1'b0, 1'b1);
      else if (r < 12) apply(gval(gidx(m_s) + 1), 1'b0, 1'b0);
      else             apply(gval(gidx(m_s) + 3), 1'b0, 1'b0);
    end

    // Mid-run reset with inputs at 11, then CLR coincident with a forward step
    set_cfg(2, 1'b0, 1);
    step_fwd(2);
    do_reset(2'b11);
    apply(2'b01, 1'b1, 1'b0);
    chk("clr_pos0", {24'b0, enc_if.POSITION}, 32'd0);
    chk("clr_dir", {31'b0, enc_if.DIR}, 32'd1);
    step_fwd(1);
    chk("after_clr_pos", {24'b0, enc_if.POSITION}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
